// File: rtl/conv_pkg.sv
// conv_pkg: shared lane/width constants, pixel types and the quantize-saturate helper
package conv_pkg;
  localparam int PIX_PER_CLK = 8;
  localparam int DATA_W = 8;
  localparam int ACC_W = 32;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [DATA_W-1:0] pix_t;
  function automatic pix_t quant_sat(input acc_t acc, input int shift);
    logic signed [ACC_W:0] r;
    r = {acc[ACC_W-1], acc};
    r = r + (shift > 0 ? (ACC_W+1)'(1) << (shift - 1) : (ACC_W+1)'(0));
    r = r >>> shift;
    return r[ACC_W] ? '0 : (|r[ACC_W-1:DATA_W]) ? '1 : r[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/conv_wb_fifo.sv
// conv_wb_fifo: show-ahead write-back FIFO; a push while full lands only with a same-cycle pop
module conv_wb_fifo #(
  parameter int W = 65,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr_en, rd_en;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout = mem[rp];
  // pointer and occupancy tracking; push+pop together leaves the count unchanged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  // storage array, contents are don't-care until written
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= din;
endmodule

// File: rtl/conv_out_dma_writer.sv
// conv_out_dma_writer: quantizes conv output beats and writes one packed word per beat to memory
module conv_out_dma_writer
  import conv_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int SHIFT = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic                          in_valid,
  input  logic signed [ACC_W-1:0]       in_pixels [PIX_PER_CLK],
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W*PIX_PER_CLK-1:0] wr_data,
  output logic                          wr_last,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);
  localparam int NW = IMG_W * IMG_H / PIX_PER_CLK;
  localparam int CW = $clog2(NW + 1);
  localparam int WW = DATA_W * PIX_PER_CLK;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] in_cnt;
  logic [ADDR_W-1:0] addr;
  logic accept, q_valid, q_last, pop, full, empty, head_last, finish;
  logic [WW-1:0] q_data, q_next, head_data;
  assign accept = state == S_RUN && in_valid && in_cnt < CW'(NW);
  assign pop = wr_valid && wr_ready;
  assign finish = (pop && wr_last) || (in_cnt == CW'(NW) && !q_valid && empty);
  assign wr_valid = !empty;
  assign wr_data = empty ? '0 : head_data;
  assign wr_last = !empty && head_last;
  assign wr_addr = addr;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  // per-lane round, shift and clamp of the incoming accumulators
  always_comb begin
    q_next = '0;
    for (int i = 0; i < PIX_PER_CLK; i++) q_next[i*DATA_W +: DATA_W] = quant_sat(in_pixels[i], SHIFT);
  end
  // single quantize register between the input beat and the FIFO
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_valid <= 1'b0;
      q_data <= '0;
      q_last <= 1'b0;
    end else begin
      q_valid <= accept;
      if (accept) begin
        q_data <= q_next;
        q_last <= in_cnt == CW'(NW - 1);
      end
    end
  // frame FSM, beat counter, output address and sticky drop flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      in_cnt <= '0;
      addr <= '0;
      overflow <= 1'b0;
    end else if (state == S_IDLE && start) begin
      state <= S_RUN;
      in_cnt <= '0;
      addr <= base_addr;
      overflow <= 1'b0;
    end else begin
      state <= state == S_RUN ? (finish ? S_DONE : S_RUN) : S_IDLE;
      if (accept) in_cnt <= in_cnt + 1'b1;
      if (pop) addr <= addr + ADDR_W'(PIX_PER_CLK);
      if (q_valid && full && !pop) overflow <= 1'b1;
    end
  conv_wb_fifo #(.W(WW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(q_valid),
    .pop(pop),
    .din({q_last, q_data}),
    .dout({head_last, head_data}),
    .full(full),
    .empty(empty)
  );
endmodule
